mem_access_stage: RTL and testbench



---
 rtl/mem_access_stage.sv | 140 ++++++++++++++
 tb/tb_mem_access_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// mem_access_stage : EX->MEM stage; ALU pass-through or 1/2-word bus access
// Rev 1.0 : initial release
// ============================================================================
module mem_access_stage #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  InValid,
   output logic                  InReady,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic                  Wide,
   input  logic [DATA_W-1:0]     ExResult,
   input  logic [ADDR_W-1:0]     ExAddress,
   input  logic [2*DATA_W-1:0]   StoreData,
   input  logic                  RegWriteIn,
   input  logic [2:0]            RdIn,
   input  logic                  Flush,
   output logic                  MemReq,
   output logic                  MemWe,
   output logic [ADDR_W-1:0]     MemAddr,
   output logic [DATA_W-1:0]     MemWData,
   input  logic                  MemAck,
   input  logic [DATA_W-1:0]     MemRData,
   output logic                  OutValid,
   output logic [2*DATA_W-1:0]   OutData,
   output logic                  OutRegWrite,
   output logic [2:0]            OutRd
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_WORD0 = 2'd1;
   localparam logic [1:0] c_WORD1 = 2'd2;

   logic [1:0]          r_state;
   logic                r_we;
   logic                r_wide;
   logic [ADDR_W-1:0]   r_addr;
   logic [2*DATA_W-1:0] r_store;
   logic                r_regwr;
   logic [2:0]          r_rd;
   logic                r_kill;
   logic [DATA_W-1:0]   r_word0;
   logic                r_out_valid;
   logic [2*DATA_W-1:0] r_out_data;
   logic                r_out_regwrite;
   logic [2:0]          r_out_rd;

   logic                w_accept;
   logic                w_done;
   logic                w_kill_now;
   logic [2*DATA_W-1:0] w_load_data;

   assign InReady     = (r_state == c_IDLE);
   assign w_accept    = InValid & InReady;
   assign MemReq      = (r_state != c_IDLE);
   assign MemWe       = MemReq & r_we;
   assign MemAddr     = (r_state == c_WORD1) ? r_addr + {{(ADDR_W-1){1'b0}}, 1'b1} : r_addr;
   assign MemWData    = (r_state == c_WORD1) ? r_store[2*DATA_W-1:DATA_W] : r_store[DATA_W-1:0];
   assign w_done      = MemAck & (((r_state == c_WORD0) & ~r_wide) | (r_state == c_WORD1));
   assign w_kill_now  = r_kill | Flush;
   // Word 0 of a wide load is staged so OutData only changes on completion
   assign w_load_data = (r_state == c_WORD1) ? {MemRData, r_word0}
                                             : {{DATA_W{1'b0}}, MemRData};

   assign OutValid    = r_out_valid;
   assign OutData     = r_out_data;
   assign OutRegWrite = r_out_regwrite;
   assign OutRd       = r_out_rd;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state        <= c_IDLE;
         r_we           <= 1'b0;
         r_wide         <= 1'b0;
         r_addr         <= '0;
         r_store        <= '0;
         r_regwr        <= 1'b0;
         r_rd           <= '0;
         r_kill         <= 1'b0;
         r_word0        <= '0;
         r_out_valid    <= 1'b0;
         r_out_data     <= '0;
         r_out_regwrite <= 1'b0;
         r_out_rd       <= '0;
      end else begin
         r_out_valid    <= 1'b0;
         r_out_regwrite <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (w_accept && !Flush) begin
                  if (MemRead || MemWrite) begin
                     r_we    <= MemWrite;
                     r_wide  <= Wide;
                     r_addr  <= ExAddress;
                     r_store <= StoreData;
                     r_regwr <= RegWriteIn;
                     r_rd    <= RdIn;
                     r_kill  <= 1'b0;
                     r_state <= c_WORD0;
                  end else begin
                     r_out_valid    <= 1'b1;
                     r_out_data     <= {{DATA_W{1'b0}}, ExResult};
                     r_out_regwrite <= RegWriteIn;
                     r_out_rd       <= RdIn;
                  end
               end
            end
            c_WORD0, c_WORD1: begin
               if (Flush) begin
                  r_kill <= 1'b1;
               end
               if (MemAck && r_state == c_WORD0 && r_wide) begin
                  r_word0 <= MemRData;
                  r_state <= c_WORD1;
               end
               if (w_done) begin
                  r_state <= c_IDLE;
                  r_kill  <= 1'b0;
                  if (!w_kill_now) begin
                     r_out_valid <= 1'b1;
                     r_out_rd    <= r_rd;
                     if (!r_we) begin
                        r_out_data     <= w_load_data;
                        r_out_regwrite <= r_regwr;
                     end
                  end
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_access_stage : self-checking bench for mem_access_stage
// Rev 1.0 : initial release
// ============================================================================
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        InValid, InReady, MemRead, MemWrite, Wide, RegWriteIn, Flush;
   logic [15:0] ExResult;
   logic [31:0] ExAddress, StoreData;
   logic [2:0]  RdIn, OutRd;
   logic        MemReq, MemWe, MemAck, OutValid, OutRegWrite;
   logic [31:0] MemAddr, OutData;
   logic [15:0] MemWData, MemRData;

   mem_access_stage #(.DATA_W(16), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady),
      .MemRead(MemRead), .MemWrite(MemWrite), .Wide(Wide),
      .ExResult(ExResult), .ExAddress(ExAddress), .StoreData(StoreData),
      .RegWriteIn(RegWriteIn), .RdIn(RdIn), .Flush(Flush),
      .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
      .MemAck(MemAck), .MemRData(MemRData), .OutValid(OutValid),
      .OutData(OutData), .OutRegWrite(OutRegWrite), .OutRd(OutRd)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        regwr;
      logic [2:0]  rd;
   } exp_t;

   typedef struct {
      logic [15:0] res;
      logic [2:0]  rd;
      logic        regwr;
      logic        flush;
      logic        exp_valid;
      logic [31:0] exp_data;
   } pt_vec_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] m_out_data;
   pt_vec_t     pt[5];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: every completion pulse must match the oldest expectation
   always @(posedge clk) begin
      #1;
      if (OutValid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_outvalid: got 1 expected 0 (t=%0t)", $time);
         end else begin
            mon_e = sb.pop_front();
            check("sb_outdata", {32'h0, OutData}, {32'h0, mon_e.data});
            check("sb_regwrite", {63'h0, OutRegWrite}, {63'h0, mon_e.regwr});
            check("sb_rd", {61'h0, OutRd}, {61'h0, mon_e.rd});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic mem_op(input logic is_rd, input logic is_wr, input logic wide,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic regwr, input logic [2:0] rd,
                         input int d0, input int d1,
                         input logic [15:0] rd0, input logic [15:0] rd1,
                         input logic flush1);
      logic [31:0] exp_data;
      logic [31:0] a1;
      a1       = addr + 32'd1;
      exp_data = is_wr ? m_out_data : (wide ? {rd1, rd0} : {16'h0, rd0});
      InValid = 1'b1; MemRead = is_rd; MemWrite = is_wr; Wide = wide;
      ExAddress = addr; StoreData = sdata; RegWriteIn = regwr; RdIn = rd; Flush = 1'b0;
      if (!flush1) begin
         sb.push_back('{data: exp_data, regwr: (!is_wr) & regwr, rd: rd});
         m_out_data = exp_data;
      end
      tick;
      InValid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Wide = 1'b0;
      for (int i = 0; i <= d0; i++) begin
         check("w0_req", {63'h0, MemReq}, 64'd1);
         check("w0_inready", {63'h0, InReady}, 64'd0);
         check("w0_addr", {32'h0, MemAddr}, {32'h0, addr});
         check("w0_we", {63'h0, MemWe}, {63'h0, is_wr});
         if (is_wr) check("w0_wdata", {48'h0, MemWData}, {48'h0, sdata[15:0]});
         check("w0_valid", {63'h0, OutValid}, 64'd0);
         if (i == d0) begin MemAck = 1'b1; MemRData = rd0; end
         tick;
         MemAck = 1'b0; MemRData = 16'h0;
      end
      if (wide) begin
         for (int i = 0; i <= d1; i++) begin
            check("w1_req", {63'h0, MemReq}, 64'd1);
            check("w1_addr", {32'h0, MemAddr}, {32'h0, a1});
            check("w1_we", {63'h0, MemWe}, {63'h0, is_wr});
            if (is_wr) check("w1_wdata", {48'h0, MemWData}, {48'h0, sdata[31:16]});
            check("w1_valid", {63'h0, OutValid}, 64'd0);
            Flush = flush1 && (i == 0);
            if (i == d1) begin MemAck = 1'b1; MemRData = rd1; end
            tick;
            MemAck = 1'b0; MemRData = 16'h0; Flush = 1'b0;
         end
      end
      check("done_req", {63'h0, MemReq}, 64'd0);
      check("done_inready", {63'h0, InReady}, 64'd1);
      check("done_valid", {63'h0, OutValid}, {63'h0, !flush1});
      check("done_regwrite", {63'h0, OutRegWrite}, {63'h0, (!flush1) & (!is_wr) & regwr});
   endtask

   initial begin
      pt[0] = '{res: 16'h8001, rd: 3'd3, regwr: 1'b1, flush: 1'b0, exp_valid: 1'b1, exp_data: 32'h0000_8001};
      pt[1] = '{res: 16'hFFFF, rd: 3'd7, regwr: 1'b0, flush: 1'b0, exp_valid: 1'b1, exp_data: 32'h0000_FFFF};
      pt[2] = '{res: 16'h0000, rd: 3'd0, regwr: 1'b1, flush: 1'b0, exp_valid: 1'b1, exp_data: 32'h0000_0000};
      pt[3] = '{res: 16'h1234, rd: 3'd5, regwr: 1'b1, flush: 1'b1, exp_valid: 1'b0, exp_data: 32'h0000_0000};
      pt[4] = '{res: 16'hA5A5, rd: 3'd2, regwr: 1'b1, flush: 1'b0, exp_valid: 1'b1, exp_data: 32'h0000_A5A5};

      rst = 1'b0; InValid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Wide = 1'b0;
      ExResult = 16'h0; ExAddress = 32'h0; StoreData = 32'h0; RegWriteIn = 1'b0;
      RdIn = 3'd0; Flush = 1'b0; MemAck = 1'b0; MemRData = 16'h0;
      m_out_data = 32'h0;
      tick; tick;
      check("rst_memreq", {63'h0, MemReq}, 64'd0);
      check("rst_memwe", {63'h0, MemWe}, 64'd0);
      check("rst_memaddr", {32'h0, MemAddr}, 64'd0);
      check("rst_memwdata", {48'h0, MemWData}, 64'd0);
      check("rst_outvalid", {63'h0, OutValid}, 64'd0);
      check("rst_outdata", {32'h0, OutData}, 64'd0);
      check("rst_outregwrite", {63'h0, OutRegWrite}, 64'd0);
      check("rst_outrd", {61'h0, OutRd}, 64'd0);
      rst = 1'b1;
      tick;
      check("rst_inready", {63'h0, InReady}, 64'd1);

      // Back-to-back pass-through ops, including one flushed at accept
      for (int i = 0; i < 5; i++) begin
         check("pt_inready", {63'h0, InReady}, 64'd1);
         InValid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; ExResult = pt[i].res;
         RdIn = pt[i].rd; RegWriteIn = pt[i].regwr; Flush = pt[i].flush;
         if (pt[i].exp_valid) begin
            sb.push_back('{data: pt[i].exp_data, regwr: pt[i].regwr, rd: pt[i].rd});
            m_out_data = pt[i].exp_data;
         end
         tick;
         InValid = 1'b0; Flush = 1'b0;
         check("pt_valid", {63'h0, OutValid}, {63'h0, pt[i].exp_valid});
         check("pt_regwrite", {63'h0, OutRegWrite}, {63'h0, pt[i].exp_valid & pt[i].regwr});
         check("pt_memreq", {63'h0, MemReq}, 64'd0);
      end
      tick;
      check("pt_idle_valid", {63'h0, OutValid}, 64'd0);
      check("pt_hold_data", {32'h0, OutData}, {32'h0, m_out_data});

      // Ack while idle must be ignored
      MemAck = 1'b1; MemRData = 16'hFFFF;
      tick;
      MemAck = 1'b0;
      check("idle_ack_req", {63'h0, MemReq}, 64'd0);
      check("idle_ack_valid", {63'h0, OutValid}, 64'd0);

      // is_rd is_wr wide addr sdata regwr rd d0 d1 rd0 rd1 flush1
      mem_op(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 3'd4, 2, 0, 16'hBEEF, 16'h0, 1'b0);
      mem_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 3'd1, 0, 0, 16'h0, 16'h0, 1'b0);
      mem_op(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 1'b1, 3'd6, 0, 0, 16'hAAAA, 16'h5555, 1'b0);
      mem_op(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_CAFE, 1'b1, 3'd2, 1, 0, 16'h0, 16'h0, 1'b0);
      mem_op(1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 1'b1, 3'd5, 1, 1, 16'h1111, 16'h2222, 1'b1);

      // Flushed load must leave the stage ready for the very next instruction
      InValid = 1'b1; ExResult = 16'h0F0F; RdIn = 3'd7; RegWriteIn = 1'b1;
      sb.push_back('{data: 32'h0000_0F0F, regwr: 1'b1, rd: 3'd7});
      m_out_data = 32'h0000_0F0F;
      tick;
      InValid = 1'b0;
      check("post_flush_valid", {63'h0, OutValid}, 64'd1);

      // Reset in the middle of an access abandons it
      InValid = 1'b1; MemRead = 1'b1; ExAddress = 32'h0000_0040; RegWriteIn = 1'b1; RdIn = 3'd3;
      tick;
      InValid = 1'b0; MemRead = 1'b0;
      check("mid_req_before", {63'h0, MemReq}, 64'd1);
      rst = 1'b0;
      tick;
      check("mid_req_after", {63'h0, MemReq}, 64'd0);
      check("mid_valid_after", {63'h0, OutValid}, 64'd0);
      check("mid_outdata_after", {32'h0, OutData}, 64'd0);
      rst = 1'b1;
      m_out_data = 32'h0;
      tick;
      check("mid_inready", {63'h0, InReady}, 64'd1);
      check("mid_valid_idle", {63'h0, OutValid}, 64'd0);

      tick; tick;
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
